i2s_tx: RTL and testbench
=========================

Name: i2s_tx

Overview:
- I2S transmitter: serializes left/right PCM samples to an external I2S DAC or codec, which is the playback counterpart of the microphone receive path.
- It generates BCLK and LRCLK from the system clock, takes sample pairs over a valid/ready handshake, and holds one pair in a single-entry buffer.
- When no sample is available at a frame boundary, it transmits silence and flags an underrun.

Parameters:
- WIDTH, 16: sample width in bits; legal range 1..SLOT_BITS-1.
- SLOT_BITS, 32: BCLK periods per channel slot; one frame is 2*SLOT_BITS BCLK periods.
- CLK_DIV, 4: system clocks per BCLK half-period; must be >= 2.

Ports:
- clk  in  1  system clock; everything is synchronous to its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- sample_valid  in  1  the left_data/right_data pair is valid.
- sample_ready  out  1  the holding buffer is empty and can accept a pair.
- left_data  in  WIDTH  left sample, two's complement.
- right_data  in  WIDTH  right sample, two's complement.
- i2s_bclk  out  1  bit clock, registered.
- i2s_lrclk  out  1  word select: 0 = left, 1 = right, registered.
- i2s_sdata  out  1  serial data, MSB first, registered.
- frame_start  out  1  one-clk pulse when a new frame begins (left slot position 0).
- underrun  out  1  one-clk pulse when a frame begins with the holding buffer empty.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears the following:
  - div counter = 0.
  - Frame position p = 2*SLOT_BITS-1.
  - i2s_bclk=0, i2s_lrclk=0, i2s_sdata=0.
  - Holding buffer empty, so sample_ready=1.
  - Both shift registers = 0.
  - frame_start=0, underrun=0.
- Reset asserted mid-frame aborts the frame immediately. Any held pair is discarded.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - When div==CLK_DIV-1, i2s_bclk toggles, so the BCLK period is 2*CLK_DIV clks.
  - A toggle 0->1 is a rise tick. A toggle 1->0 is a fall tick.
  - After reset release, the first rise tick is at clk CLK_DIV and the first fall tick at clk 2*CLK_DIV.
- Frame position:
  - On each fall tick, p <= (p+1) mod 2*SLOT_BITS.
  - Outputs for the new p are registered on that same clk edge, together with the bclk falling edge.
  - Data is therefore stable across the next rising BCLK edge, where the receiver samples.
- Slot decode:
  - s = p / SLOT_BITS (0 = left, 1 = right).
  - k = p mod SLOT_BITS.
  - i2s_lrclk = s.
  - i2s_sdata = 0 when k==0. This gives the standard I2S one-bit delay after the LRCLK edge.
  - For k in 1..WIDTH, i2s_sdata = sample[WIDTH-k] of the slot's channel.
  - For k > WIDTH, i2s_sdata = 0 (zero padding).
- Load, on the fall tick where p becomes 0:
  - If the holding buffer is full: both shift registers load the held pair, the buffer clears, and sample_ready returns to 1 on the next clk.
  - If the holding buffer is empty: both shift registers load 0 and underrun pulses.
  - frame_start pulses on this edge in both cases.
  - The right sample is latched here together with the left sample; it is not re-read at the right-slot start.
- Handshake:
  - sample_ready = !hold_full, driven from a register.
  - A transfer occurs on a clk where sample_valid && sample_ready; the pair goes to the holding buffer and hold_full sets.
  - A transfer on the same clk as an empty-buffer load does not feed the current frame. The pair is held for the next frame, and underrun still pulses.
  - sample_valid while sample_ready=0 is ignored. The source must hold its data until ready.
- Throughput: one pair per frame, i.e. 4*SLOT_BITS*CLK_DIV clks per pair.

Test Plan:
- Reset defaults:
  - Stimulus: WIDTH=16, SLOT_BITS=32, CLK_DIV=2; hold rst_n=0 for 3 clks, then release.
  - Required: during reset, bclk/lrclk/sdata=0 and sample_ready=1.
  - Required: the first bclk rise is at clk 2 and the first fall at clk 4, with frame_start and underrun pulsing on the clk-4 edge.
- Single pair:
  - Stimulus: push left=16'hA5F0, right=16'h0F3C before the first frame start.
  - Required: sampling sdata on bclk rising edges gives lrclk=0 with bits 0,1010010111110000, then 15 zeros; then lrclk=1 with bits 0,0000111100111100, then 15 zeros.
  - Required: no underrun pulse on that frame.
- Backpressure:
  - Stimulus: hold sample_valid=1 with a new pair each accept.
  - Required: exactly one accept per 256 clks, and sample_ready is low between the accept and the next frame start.
  - Required: consecutive frames carry consecutive pairs.
- Underrun:
  - Stimulus: stop sending after one pair.
  - Required: the following frame is all zeros on sdata, underrun pulses once per frame, and LRCLK/BCLK continue uninterrupted.
- Simultaneous load and accept:
  - Stimulus: assert valid on exactly the clk of an empty-buffer frame start.
  - Required: the current frame is silent and underrun=1; the pair appears in the next frame.
- Mid-frame reset:
  - Stimulus: assert rst_n=0 at p=40 with a held pair.
  - Required: all outputs return to reset values on the next clk; after release, the first frame is an underrun (the held pair is discarded).

Source files
------------

// File: rtl/i2s_tx_if.sv
// Sample handshake bundle for the I2S transmitter.
// Master is the PCM source, slave is i2s_tx.
interface i2s_tx_if #(
  parameter int WIDTH = 16
);
  logic             sample_valid;
  logic             sample_ready;
  logic [WIDTH-1:0] left_data;
  logic [WIDTH-1:0] right_data;

  modport master (
    output sample_valid,
    output left_data,
    output right_data,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  left_data,
    input  right_data,
    output sample_ready
  );
endinterface

// File: rtl/i2s_tx.sv
// I2S transmitter: BCLK/LRCLK generation, one-pair holding buffer,
// MSB-first serialization with one-bit delay and underrun signalling.
module i2s_tx #(
  parameter int WIDTH     = 16,
  parameter int SLOT_BITS = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic    clk,
  input  logic    rst_n,
  i2s_tx_if.slave bus,
  output logic    i2s_bclk,
  output logic    i2s_lrclk,
  output logic    i2s_sdata,
  output logic    frame_start,
  output logic    underrun
);

  localparam int FRAME = 2 * SLOT_BITS;
  localparam int PW    = $clog2(FRAME);
  localparam int DW    = $clog2(CLK_DIV);

  localparam logic [PW-1:0] P_LAST = PW'(FRAME - 1);
  localparam logic [PW-1:0] P_SLOT = PW'(SLOT_BITS);
  localparam logic [PW-1:0] P_WID  = PW'(WIDTH);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]    r_div;
  logic [PW-1:0]    r_p;
  logic             r_bclk;
  logic             r_lrclk;
  logic             r_sdata;
  logic             r_fs;
  logic             r_ur;
  logic             r_full;
  logic             r_ready;
  logic [WIDTH-1:0] r_hold_l;
  logic [WIDTH-1:0] r_hold_r;
  logic [WIDTH-1:0] r_sh_l;
  logic [WIDTH-1:0] r_sh_r;

  logic             w_tick;
  logic             w_fall;
  logic [PW-1:0]    w_pinc;
  logic             w_slot;
  logic [PW-1:0]    w_k;
  logic             w_bit;
  logic             w_load;
  logic             w_xfer;

  logic [DW-1:0]    w_div_nxt;
  logic [PW-1:0]    w_p_nxt;
  logic             w_bclk_nxt;
  logic             w_lr_nxt;
  logic             w_sd_nxt;
  logic             w_full_nxt;
  logic [WIDTH-1:0] w_hold_l_nxt;
  logic [WIDTH-1:0] w_hold_r_nxt;
  logic [WIDTH-1:0] w_sh_l_nxt;
  logic [WIDTH-1:0] w_sh_r_nxt;

  // Slot decode is done on the position being entered, so the
  // outputs move together with the falling BCLK edge.
  assign w_tick = (r_div == D_LAST);
  assign w_fall = w_tick & r_bclk;
  assign w_pinc = (r_p == P_LAST) ? '0 : r_p + 1'b1;
  assign w_slot = (w_pinc >= P_SLOT);
  assign w_k    = w_slot ? w_pinc - P_SLOT : w_pinc;
  assign w_bit  = (w_k != '0) && (w_k <= P_WID);
  assign w_load = w_fall && (w_pinc == '0);
  assign w_xfer = bus.sample_valid & r_ready;

  always_comb begin
    w_div_nxt  = w_tick ? '0 : r_div + 1'b1;
    w_bclk_nxt = r_bclk ^ w_tick;
    w_p_nxt    = r_p;
    w_lr_nxt   = r_lrclk;
    w_sd_nxt   = r_sdata;
    w_sh_l_nxt = r_sh_l;
    w_sh_r_nxt = r_sh_r;
    if (w_fall) begin
      w_p_nxt  = w_pinc;
      w_lr_nxt = w_slot;
      w_sd_nxt = 1'b0;
      if (w_load) begin
        w_sh_l_nxt = r_full ? r_hold_l : '0;
        w_sh_r_nxt = r_full ? r_hold_r : '0;
      end else if (w_bit) begin
        if (w_slot) begin
          w_sd_nxt   = r_sh_r[WIDTH-1];
          w_sh_r_nxt = r_sh_r << 1;
        end else begin
          w_sd_nxt   = r_sh_l[WIDTH-1];
          w_sh_l_nxt = r_sh_l << 1;
        end
      end
    end
  end

  // A pair accepted on an empty-buffer load edge stays held for
  // the following frame; the current frame still goes out silent.
  always_comb begin
    w_hold_l_nxt = w_xfer ? bus.left_data  : r_hold_l;
    w_hold_r_nxt = w_xfer ? bus.right_data : r_hold_r;
    w_full_nxt   = (w_load && r_full) ? 1'b0 : (r_full | w_xfer);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div    <= '0;
      r_p      <= P_LAST;
      r_bclk   <= 1'b0;
      r_lrclk  <= 1'b0;
      r_sdata  <= 1'b0;
      r_fs     <= 1'b0;
      r_ur     <= 1'b0;
      r_full   <= 1'b0;
      r_ready  <= 1'b1;
      r_hold_l <= '0;
      r_hold_r <= '0;
      r_sh_l   <= '0;
      r_sh_r   <= '0;
    end else begin
      r_div    <= w_div_nxt;
      r_p      <= w_p_nxt;
      r_bclk   <= w_bclk_nxt;
      r_lrclk  <= w_lr_nxt;
      r_sdata  <= w_sd_nxt;
      r_fs     <= w_load;
      r_ur     <= w_load & ~r_full;
      r_full   <= w_full_nxt;
      r_ready  <= ~w_full_nxt;
      r_hold_l <= w_hold_l_nxt;
      r_hold_r <= w_hold_r_nxt;
      r_sh_l   <= w_sh_l_nxt;
      r_sh_r   <= w_sh_r_nxt;
    end
  end

  assign i2s_bclk         = r_bclk;
  assign i2s_lrclk        = r_lrclk;
  assign i2s_sdata        = r_sdata;
  assign frame_start      = r_fs;
  assign underrun         = r_ur;
  assign bus.sample_ready = r_ready;

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: reset, serialization, backpressure,
// underrun, same-edge accept and mid-frame reset.
module tb_i2s_tx;
  localparam int W  = 16;
  localparam int SB = 32;
  localparam int CD = 2;
  localparam logic [63:0] LR_EXP = {32'h0, 32'hFFFF_FFFF};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bclk, lrclk, sdata, fs, ur;

  i2s_tx_if #(.WIDTH(W)) bus ();

  i2s_tx #(
    .WIDTH    (W),
    .SLOT_BITS(SB),
    .CLK_DIV  (CD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .i2s_bclk   (bclk),
    .i2s_lrclk  (lrclk),
    .i2s_sdata  (sdata),
    .frame_start(fs),
    .underrun   (ur)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ef(input logic [15:0] l,
                                     input logic [15:0] r);
    return {1'b0, l, 15'd0, 1'b0, r, 15'd0};
  endfunction

  typedef struct {
    logic [63:0] d;
    logic [63:0] lr;
    int n;
    int ur;
    int sc;
  } frame_t;

  frame_t frames[$];
  frame_t cur;
  bit have;
  logic pb;
  int last_rise;
  int bclk_bad;

  // Frame monitor: samples sdata/lrclk on each BCLK rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      have = 1'b0;
      pb = 1'b0;
      last_rise = -1;
    end else begin
      if (fs) begin
        if (have) frames.push_back(cur);
        cur.d = '0;
        cur.lr = '0;
        cur.n = 0;
        cur.ur = 0;
        cur.sc = cyc;
        have = 1'b1;
      end
      if (ur && have) cur.ur++;
      if (bclk && !pb) begin
        if (last_rise >= 0 && cyc - last_rise != 2 * CD) bclk_bad++;
        last_rise = cyc;
        if (have) begin
          cur.d = {cur.d[62:0], sdata};
          cur.lr = {cur.lr[62:0], lrclk};
          cur.n++;
        end
      end
      pb = bclk;
    end
  end

  logic [15:0] src_l[$];
  logic [15:0] src_r[$];
  bit src_en;
  bit pend;
  bit m_full;
  int acc[$];

  // Source driver plus expected-ready model.
  initial begin
    bus.sample_valid = 1'b0;
    bus.left_data = '0;
    bus.right_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        m_full = 1'b0;
        bus.sample_valid = 1'b0;
      end else begin
        if (pend) begin
          src_l.delete(0);
          src_r.delete(0);
          acc.push_back(cyc);
        end
        m_full = pend ? 1'b1 : (fs ? 1'b0 : m_full);
        chk("ready", 64'(bus.sample_ready), 64'(!m_full));
        if (src_en && src_l.size() > 0) begin
          bus.sample_valid = 1'b1;
          bus.left_data = src_l[0];
          bus.right_data = src_r[0];
        end else begin
          bus.sample_valid = 1'b0;
        end
        pend = bus.sample_valid && bus.sample_ready;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    frames.delete();
    acc.delete();
    bclk_bad = 0;
  endtask

  task automatic wait_frames(input int n, input string tag);
    int t;
    frame_t dummy;
    t = 0;
    while (frames.size() < n && t < n * 256 + 600) begin
      tick();
      t++;
    end
    chk(tag, 64'(frames.size() >= n), 64'd1);
    dummy.d = 'x;
    dummy.lr = 'x;
    dummy.n = -1;
    dummy.ur = -1;
    dummy.sc = -1;
    while (frames.size() < n) frames.push_back(dummy);
  endtask

  logic [15:0] pl[4];
  logic [15:0] pr[4];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    pl = '{16'h1111, 16'h8000, 16'h0001, 16'h5A5A};
    pr = '{16'hEEEE, 16'h7FFF, 16'hFFFE, 16'hC3C3};
    src_en = 1'b0;
    bclk_bad = 0;

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_bclk", 64'(bclk), 64'd0);
    chk("rst_lrclk", 64'(lrclk), 64'd0);
    chk("rst_sdata", 64'(sdata), 64'd0);
    chk("rst_ready", 64'(bus.sample_ready), 64'd1);
    chk("rst_fs", 64'(fs), 64'd0);
    chk("rst_ur", 64'(ur), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("c1_bclk", 64'(bclk), 64'd0);
    tick();
    chk("c2_bclk", 64'(bclk), 64'd1);
    chk("c2_fs", 64'(fs), 64'd0);
    tick();
    chk("c3_bclk", 64'(bclk), 64'd1);
    tick();
    chk("c4_bclk", 64'(bclk), 64'd0);
    chk("c4_fs", 64'(fs), 64'd1);
    chk("c4_ur", 64'(ur), 64'd1);
    chk("c4_lrclk", 64'(lrclk), 64'd0);
    tick();
    chk("c5_fs", 64'(fs), 64'd0);
    chk("c5_ur", 64'(ur), 64'd0);

    src_l = '{16'hA5F0};
    src_r = '{16'h0F3C};
    src_en = 1'b1;
    do_reset();
    wait_frames(3, "single_frames");
    chk("single_data", frames[0].d, ef(16'hA5F0, 16'h0F3C));
    chk("single_lr", frames[0].lr, LR_EXP);
    chk("single_nbits", 64'(frames[0].n), 64'd64);
    chk("single_ur", 64'(frames[0].ur), 64'd0);
    chk("single_start", 64'(frames[0].sc), 64'd4);
    for (int i = 1; i < 3; i++) begin
      chk("under_data", frames[i].d, 64'd0);
      chk("under_lr", frames[i].lr, LR_EXP);
      chk("under_cnt", 64'(frames[i].ur), 64'd1);
      chk("under_period", 64'(frames[i].sc - frames[i-1].sc), 64'd256);
    end
    chk("under_bclk", 64'(bclk_bad), 64'd0);

    for (int i = 0; i < 4; i++) begin
      src_l.push_back(pl[i]);
      src_r.push_back(pr[i]);
    end
    do_reset();
    wait_frames(4, "bp_frames");
    chk("bp_nacc", 64'(acc.size()), 64'd4);
    chk("bp_acc0", 64'(acc[0]), 64'd1);
    chk("bp_acc1", 64'(acc[1]), 64'd5);
    chk("bp_gap2", 64'(acc[2] - acc[1]), 64'd256);
    chk("bp_gap3", 64'(acc[3] - acc[2]), 64'd256);
    for (int i = 0; i < 4; i++) begin
      chk("bp_data", frames[i].d, ef(pl[i], pr[i]));
      chk("bp_ur", 64'(frames[i].ur), 64'd0);
    end
    chk("bp_bclk", 64'(bclk_bad), 64'd0);

    src_en = 1'b0;
    src_l = '{16'h8001};
    src_r = '{16'h7FFE};
    do_reset();
    repeat (3) tick();
    src_en = 1'b1;
    tick();
    chk("sim_fs", 64'(fs), 64'd1);
    chk("sim_ur", 64'(ur), 64'd1);
    chk("sim_ready", 64'(bus.sample_ready), 64'd0);
    wait_frames(2, "sim_frames");
    chk("sim_f0_data", frames[0].d, 64'd0);
    chk("sim_f0_ur", 64'(frames[0].ur), 64'd1);
    chk("sim_f1_data", frames[1].d, ef(16'h8001, 16'h7FFE));
    chk("sim_f1_ur", 64'(frames[1].ur), 64'd0);

    src_l = '{16'h1234, 16'h5555};
    src_r = '{16'hFFFF, 16'hAAAA};
    do_reset();
    for (int t = 0; t < 400 && cyc < 166; t++) tick();
    chk("mid_cyc", 64'(cyc), 64'd166);
    chk("mid_pre_bclk", 64'(bclk), 64'd1);
    chk("mid_pre_lrclk", 64'(lrclk), 64'd1);
    chk("mid_pre_sdata", 64'(sdata), 64'd1);
    chk("mid_pre_ready", 64'(bus.sample_ready), 64'd0);
    rst_n = 1'b0;
    tick();
    chk("mid_bclk", 64'(bclk), 64'd0);
    chk("mid_lrclk", 64'(lrclk), 64'd0);
    chk("mid_sdata", 64'(sdata), 64'd0);
    chk("mid_ready", 64'(bus.sample_ready), 64'd1);
    chk("mid_fs", 64'(fs), 64'd0);
    chk("mid_ur", 64'(ur), 64'd0);
    do_reset();
    repeat (4) tick();
    chk("mid_rel_fs", 64'(fs), 64'd1);
    chk("mid_rel_ur", 64'(ur), 64'd1);
    wait_frames(1, "mid_frames");
    chk("mid_f0_data", frames[0].d, 64'd0);
    chk("mid_f0_ur", 64'(frames[0].ur), 64'd1);
    chk("mid_f0_nbits", 64'(frames[0].n), 64'd64);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
